// File: rtl/counter_ctrl_if.sv
// counter_ctrl_if: host-side control bundle for counter_ctrl.
//   master : host/CSR front end; drives start/stop/hold/periodic/period and
//            observes count/busy/tick/done.
//   slave  : the counter controller itself.
// WIDTH must match the WIDTH of the counter_ctrl instance it connects to.
interface counter_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             stop;
  logic             hold;
  logic             periodic;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             tick;
  logic             done;

  modport master (
    output start, stop, hold, periodic, period,
    input  count, busy, tick, done
  );

  modport slave (
    input  start, stop, hold, periodic, period,
    output count, busy, tick, done
  );
endinterface

// File: rtl/counter_ctrl.sv
// counter_ctrl: sequencing controller for an up/down counter.
//   A start latches the period P (0 means 2^WIDTH) and the mode. The count
//   then runs from its start value to its terminal value: 0..P-1 when
//   counting up, P-1..0 when counting down. The step taken at the terminal
//   value either reloads the count and pulses tick (periodic), or parks the
//   count and spends one DONE cycle with tick=done=1 (one-shot).
//
// Parameters:
//   WIDTH    counter/period width (>= 2)
//   DOWN     0 = count up, 1 = count down
//   PRESCALE clock cycles per count step (>= 1); used only when the
//            TIMER_PRESCALE_EN macro is defined
//
// Ports:
//   clk   rising-edge clock
//   rstn  asynchronous active-low reset
//   bus   counter_ctrl_if.slave
//           start    start request, honoured in IDLE/DONE
//           stop     abort, honoured in RUN (beats a simultaneous terminal)
//           hold     freezes counting (and the prescaler) while high in RUN
//           periodic 1 = auto-reload, 0 = one-shot; latched at start
//           period   count length, latched at start
//           count    current count value
//           busy     high while in RUN
//           tick     one-cycle pulse after the terminal step
//           done     one-cycle pulse when a one-shot run completes
//
// Optional feature (macro TIMER_PRESCALE_EN): a prescaler gates every step
// so each count value lasts PRESCALE step-eligible cycles.
//
// Every output comes straight from a flop.
module counter_ctrl #(
  parameter int WIDTH    = 8,
  parameter bit DOWN     = 1'b0,
  parameter int PRESCALE = 4
) (
  input  logic           clk,
  input  logic           rstn,
  counter_ctrl_if.slave  bus
);

  // Parameter sanity, resolved at elaboration.
  if (WIDTH < 2) begin : g_chk_width
    $error("counter_ctrl: WIDTH must be >= 2");
  end
  if (PRESCALE < 1) begin : g_chk_prescale
    $error("counter_ctrl: PRESCALE must be >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] per_q,   per_d;     // latched period
  logic             mode_q,  mode_d;    // latched periodic flag
  logic             busy_q,  busy_d;
  logic             tick_q,  tick_d;
  logic             done_q,  done_d;

  logic             accept;     // start honoured this cycle
  logic             eligible;   // RUN cycle with neither hold nor stop
  logic             step;       // counting actually advances
  logic [WIDTH-1:0] term_val;
  logic [WIDTH-1:0] reload_val;
  logic             term_step;

  assign accept   = (state != S_RUN) && bus.start;
  assign eligible = (state == S_RUN) && !bus.hold && !bus.stop;

`ifdef TIMER_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q, pre_d;

  // Only cycles that could step advance the prescaler, so hold freezes it
  // and each count value spans exactly PRESCALE eligible cycles.
  always_comb begin
    pre_d = pre_q;
    if (accept)
      pre_d = '0;
    else if (eligible)
      pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + PW'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) pre_q <= '0;
    else       pre_q <= pre_d;
  end

  assign step = eligible && (pre_q == PRE_LAST);
`else
  assign step = eligible;
`endif

  // P=0 wraps to all-ones, which is exactly the 2^WIDTH-long range.
  assign reload_val = DOWN ? (per_q - WIDTH'(1)) : '0;
  assign term_val   = DOWN ? '0 : (per_q - WIDTH'(1));
  assign term_step  = step && (count_q == term_val);

  // ---------------- state register ----------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // ---------------- next-state logic ----------------
  // stop is folded into step (no step when stop is high), so a stop
  // coinciding with the terminal count aborts cleanly.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (bus.start) state_nxt = S_RUN;
      S_RUN: begin
        if (bus.stop)                 state_nxt = S_IDLE;
        else if (term_step && !mode_q) state_nxt = S_DONE;
      end
      S_DONE: state_nxt = bus.start ? S_RUN : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------- output / datapath next values ----------------
  always_comb begin
    count_d = count_q;
    per_d   = per_q;
    mode_d  = mode_q;
    tick_d  = 1'b0;
    done_d  = 1'b0;
    busy_d  = (state_nxt == S_RUN);
    if (accept) begin
      per_d   = bus.period;
      mode_d  = bus.periodic;
      count_d = DOWN ? (bus.period - WIDTH'(1)) : '0;
    end else if (term_step) begin
      // Terminal step never moves past the terminal value: it either
      // reloads or parks the count there for the DONE cycle.
      tick_d = 1'b1;
      if (mode_q) count_d = reload_val;
      else        done_d  = 1'b1;
    end else if (step) begin
      count_d = DOWN ? (count_q - WIDTH'(1)) : (count_q + WIDTH'(1));
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
      per_q   <= '0;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      per_q   <= per_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
    end
  end

  assign bus.count = count_q;
  assign bus.busy  = busy_q;
  assign bus.tick  = tick_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// tb_counter_ctrl: drives an up-counting and a down-counting counter_ctrl
// with identical stimulus. A run-position reference model predicts each
// cycle's outputs into a queue; a monitor pops and compares after every edge.
module tb_counter_ctrl;
  localparam int W  = 4;
  localparam int PS = 3;
`ifdef TIMER_PRESCALE_EN
  localparam int MPS = PS;
`else
  localparam int MPS = 1;
`endif
  localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  counter_ctrl_if #(.WIDTH(W)) bus_up ();
  counter_ctrl_if #(.WIDTH(W)) bus_dn ();

  counter_ctrl #(.WIDTH(W), .DOWN(1'b0), .PRESCALE(PS)) u_up (
    .clk(clk), .rstn(rstn), .bus(bus_up));
  counter_ctrl #(.WIDTH(W), .DOWN(1'b1), .PRESCALE(PS)) u_dn (
    .clk(clk), .rstn(rstn), .bus(bus_dn));

  // Model: a run is P positions k=0..P-1; count is k (up) or P-1-k (down).
  typedef struct {
    int ph; int k; int p; bit per; int pre; int cnt; bit tick; bit done;
  } mdl_t;

  typedef struct packed { logic [6:0] up; logic [6:0] dn; } exp_t;

  mdl_t mu, md;
  exp_t exp_q[$];
  int   n_chk = 0, n_err = 0;
  bit   mon_on = 1'b0;

  function automatic mdl_t mreset();
    mdl_t m;
    m.ph = M_IDLE; m.k = 0; m.p = 0; m.per = 1'b0; m.pre = 0;
    m.cnt = 0; m.tick = 1'b0; m.done = 1'b0;
    return m;
  endfunction

  function automatic mdl_t mstep(mdl_t m, bit st, bit sp, bit hd, bit pe,
                                 int pr, bit dn);
    m.tick = 1'b0;
    m.done = 1'b0;
    if (m.ph == M_RUN) begin
      if (sp) m.ph = M_IDLE;
      else if (!hd) begin
        if (m.pre == MPS - 1) begin
          m.pre = 0;
          if (m.k == m.p - 1) begin
            m.tick = 1'b1;
            if (m.per) m.k = 0;
            else begin m.ph = M_DONE; m.done = 1'b1; end
          end else m.k++;
        end else m.pre++;
      end
    end else if (st) begin
      m.ph = M_RUN; m.p = (pr == 0) ? (1 << W) : pr; m.per = pe;
      m.k = 0; m.pre = 0;
    end else m.ph = M_IDLE;
    if (m.ph != M_IDLE) m.cnt = (dn ? (m.p - 1 - m.k) : m.k) % (1 << W);
    return m;
  endfunction

  function automatic logic [6:0] pk(mdl_t m);
    logic [W-1:0] c;
    c = W'(m.cnt);
    return {c, m.ph == M_RUN, m.tick, m.done};
  endfunction

  // Apply inputs for the coming edge and queue the predicted outputs.
  task automatic apply(input bit st, input bit sp, input bit hd, input bit pe,
                       input logic [W-1:0] pr);
    exp_t e;
    bus_up.start = st; bus_up.stop = sp; bus_up.hold = hd;
    bus_up.periodic = pe; bus_up.period = pr;
    bus_dn.start = st; bus_dn.stop = sp; bus_dn.hold = hd;
    bus_dn.periodic = pe; bus_dn.period = pr;
    mu = mstep(mu, st, sp, hd, pe, int'(pr), 1'b0);
    md = mstep(md, st, sp, hd, pe, int'(pr), 1'b1);
    e.up = pk(mu);
    e.dn = pk(md);
    exp_q.push_back(e);
    mon_on = 1'b1;
  endtask

  task automatic cyc(input bit st, input bit sp, input bit hd, input bit pe,
                     input logic [W-1:0] pr);
    @(negedge clk);
    apply(st, sp, hd, pe, pr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic chk_zero(input string name);
    logic [6:0] gu, gd;
    gu = {bus_up.count, bus_up.busy, bus_up.tick, bus_up.done};
    gd = {bus_dn.count, bus_dn.busy, bus_dn.tick, bus_dn.done};
    n_chk += 2;
    if (gu !== 7'd0) begin
      n_err++; $display("FAIL %s up: got %b want 0000000", name, gu);
    end
    if (gd !== 7'd0) begin
      n_err++; $display("FAIL %s dn: got %b want 0000000", name, gd);
    end
  endtask

  // Asynchronous reset in the middle of a cycle, held across one edge.
  task automatic mid_reset();
    exp_t e;
    @(negedge clk);
    #2 rstn = 1'b0;
    #1 chk_zero("async_reset");
    mu = mreset();
    md = mreset();
    e.up = pk(mu);
    e.dn = pk(md);
    exp_q.push_back(e);
    @(negedge clk);
    rstn = 1'b1;
    apply(1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  // Monitor: outputs are valid every cycle, so one compare per edge.
  always begin
    logic [6:0] gu, gd;
    exp_t e;
    @(posedge clk);
    #1;
    if (mon_on) begin
      gu = {bus_up.count, bus_up.busy, bus_up.tick, bus_up.done};
      gd = {bus_dn.count, bus_dn.busy, bus_dn.tick, bus_dn.done};
      n_chk++;
      if (exp_q.size() == 0) begin
        n_err++; $display("FAIL sb_underflow at %0t: no expected entry", $time);
      end else begin
        e = exp_q.pop_front();
        if (gu !== e.up || gd !== e.dn) begin
          n_err++;
          $display("FAIL cycle_out at %0t: up got %b want %b, dn got %b want %b (cnt,busy,tick,done)",
                   $time, gu, e.up, gd, e.dn);
        end
      end
    end
  end

  initial begin
    bit st, sp, hd, pe;
    logic [W-1:0] pr;
    int r;
    mu = mreset();
    md = mreset();
    bus_up.start = 0; bus_up.stop = 0; bus_up.hold = 0; bus_up.periodic = 0;
    bus_up.period = '0;
    bus_dn.start = 0; bus_dn.stop = 0; bus_dn.hold = 0; bus_dn.periodic = 0;
    bus_dn.period = '0;
    #3 chk_zero("reset_state");
    @(negedge clk);
    rstn = 1'b1;

    // One-shot P=4, then periodic P=3 followed by an abort.
    cyc(1, 0, 0, 0, 4'd4); idle(7);
    cyc(1, 0, 0, 1, 4'd3); idle(8);
    cyc(0, 1, 0, 0, '0);   idle(2);
    // One-shot P=5 with hold on the second and third run cycles.
    cyc(1, 0, 0, 0, 4'd5); idle(1);
    cyc(0, 0, 1, 0, '0); cyc(0, 0, 1, 0, '0); idle(8);
    // Periodic P=4 aborted on its terminal cycle.
    cyc(1, 0, 0, 1, 4'd4); idle(3); cyc(0, 1, 0, 0, '0); idle(2);
    // One-shot P=2 restarted from its DONE cycle.
    cyc(1, 0, 0, 0, 4'd2); idle(2); cyc(1, 0, 0, 0, 4'd2); idle(8);
    // P=1 periodic: tick on every step.
    cyc(1, 0, 0, 1, 4'd1); idle(5); cyc(0, 1, 0, 0, '0); idle(1);
    // Full range (P=0), then again with reset mid-run.
    cyc(1, 0, 0, 0, 4'd0); idle(20 * MPS);
    cyc(1, 0, 0, 0, 4'd0); idle(7);
    mid_reset(); idle(2);

    // Randomised traffic with occasional async resets.
    for (int i = 0; i < 3000; i++) begin
      st = ($urandom % 4) == 0;
      sp = ($urandom % 12) == 0;
      hd = ($urandom % 5) == 0;
      pe = $urandom % 2;
      r  = $urandom % 4;
      case (r)
        0:       pr = W'($urandom % 16);
        1:       pr = W'(1);
        2:       pr = '0;
        default: pr = W'($urandom % 4);
      endcase
      if (i % 700 == 699) mid_reset();
      else cyc(st, sp, hd, pe, pr);
    end

    @(posedge clk);
    #3;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL sb_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
